// File: rtl/regfile_mp.sv
// Multi-ported register file with an issue/writeback scoreboard.
// r0 is hardwired to zero and never pending; optional same-cycle
// write-to-read forwarding; asynchronous active-high reset.
module regfile_mp #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          NUM_REGS = 32,
    parameter int unsigned          NUM_RD   = 2,
    parameter int unsigned          NUM_WR   = 2,
    parameter int unsigned          BYPASS   = 1,
    parameter logic [DATA_W-1:0]    SP_INIT  = '0,
    parameter logic [DATA_W-1:0]    RA_INIT  = '0,
    localparam int unsigned         AW       = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_WR-1:0]           wr_en,
    input  logic [NUM_WR*AW-1:0]        wr_num,
    input  logic [NUM_WR*DATA_W-1:0]    wr_data,
    input  logic [NUM_RD*AW-1:0]        rd_num,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic                        iss_en,
    input  logic [AW-1:0]               iss_num,
    output logic [NUM_REGS-1:0]         busy_vec
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [AW-1:0]       src;
    logic [DATA_W-1:0]   src_data;
    logic                src_hit;

    // Reset value of register idx: stack and return-address registers are
    // preloaded only when the file is large enough to contain them.
    function automatic logic [DATA_W-1:0] reset_value(input int unsigned idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (NUM_REGS >= 32 && idx == 29) v = SP_INIT;
        if (NUM_REGS >= 32 && idx == 31) v = RA_INIT;
        return v;
    endfunction

    // Next register contents and scoreboard; later ports override earlier
    // ones, and an issue re-sets a bit that a same-cycle write cleared.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        for (int unsigned q = 0; q < NUM_WR; q++) begin
            if (wr_en[q] && wr_num[q*AW +: AW] != '0) begin
                regs_d[wr_num[q*AW +: AW]] = wr_data[q*DATA_W +: DATA_W];
                busy_d[wr_num[q*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en && iss_num != '0) begin
            busy_d[iss_num] = 1'b1;
        end
        regs_d[0]  = '0;
        busy_d[0]  = 1'b0;
    end

    // Combinational read ports with optional forwarding from the write ports.
    always_comb begin
        rd_data  = '0;
        rd_busy  = '0;
        src      = '0;
        src_data = '0;
        src_hit  = 1'b0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            src      = rd_num[p*AW +: AW];
            src_data = regs_q[src];
            src_hit  = 1'b0;
            if (BYPASS == 1 && src != '0) begin
                for (int unsigned q = 0; q < NUM_WR; q++) begin
                    if (wr_en[q] && wr_num[q*AW +: AW] == src) begin
                        src_data = wr_data[q*DATA_W +: DATA_W];
                        src_hit  = 1'b1;
                    end
                end
            end
            if (src == '0) begin
                src_data = '0;
            end
            rd_data[p*DATA_W +: DATA_W] = src_data;
            rd_busy[p] = busy_q[src] & ~src_hit;
        end
    end

    // State registers; reset clears the scoreboard without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= reset_value(i);
            end
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic compared against an array-based reference model.
module tb_regfile_mp;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] RA = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wr_en;
    logic [9:0]  wr_num;
    logic [63:0] wr_data;
    logic [9:0]  rd_num;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        iss_en;
    logic [4:0]  iss_num;
    logic [31:0] busy_vec;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    int          tests;
    int          fails;

    regfile_mp #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .NUM_WR   (2),
        .BYPASS   (1),
        .SP_INIT  (SP),
        .RA_INIT  (RA)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_num   (wr_num),
        .wr_data  (wr_data),
        .rd_num   (rd_num),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .iss_en   (iss_en),
        .iss_num  (iss_num),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_regs[29] = SP;
        m_regs[31] = RA;
        m_busy = 32'h0;
    endtask

    task automatic drive(input logic we0, input logic [4:0] n0, input logic [31:0] d0,
                         input logic we1, input logic [4:0] n1, input logic [31:0] d1,
                         input logic ie, input logic [4:0] inum,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en   = {we1, we0};
        wr_num  = {n1, n0};
        wr_data = {d1, d0};
        iss_en  = ie;
        iss_num = inum;
        rd_num  = {r1, r0};
    endtask

    // Compare both read ports and the scoreboard with the model.
    task automatic check_model(input string tag);
        logic [4:0]  n;
        logic [31:0] exp_d;
        logic        exp_b;
        for (int p = 0; p < 2; p++) begin
            n = rd_num[p*5 +: 5];
            exp_d = 32'h0;
            exp_b = 1'b0;
            if (n != 5'd0) begin
                exp_d = m_regs[n];
                exp_b = m_busy[n];
                // highest-numbered matching writer forwards its data
                for (int q = 1; q >= 0; q--) begin
                    if (wr_en[q] && wr_num[q*5 +: 5] == n) begin
                        exp_d = wr_data[q*32 +: 32];
                        exp_b = 1'b0;
                        break;
                    end
                end
            end
            chk($sformatf("%s_rd%0d_data", tag, p), rd_data[p*32 +: 32], exp_d);
            chk($sformatf("%s_rd%0d_busy", tag, p), {31'h0, rd_busy[p]}, {31'h0, exp_b});
        end
        chk($sformatf("%s_busy_vec", tag), busy_vec, m_busy);
    endtask

    // Advance one clock edge, applying the current inputs to the model.
    task automatic tick();
        logic [31:0] nregs [32];
        logic [31:0] nbusy;
        for (int i = 0; i < 32; i++) nregs[i] = m_regs[i];
        nbusy = m_busy;
        for (int q = 0; q < 2; q++) begin
            if (wr_en[q] && wr_num[q*5 +: 5] != 5'd0) begin
                nregs[wr_num[q*5 +: 5]] = wr_data[q*32 +: 32];
                nbusy[wr_num[q*5 +: 5]] = 1'b0;
            end
        end
        if (iss_en && iss_num != 5'd0) nbusy[iss_num] = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) m_regs[i] = nregs[i];
        m_busy = nbusy;
    endtask

    function automatic logic [4:0] rnum();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        // write and issue held during reset must be discarded
        drive(1'b1, 5'd5, 32'h5555, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd29, 5'd31);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_vec", busy_vec, 32'h0);
        chk("rst_rd_busy", {30'h0, rd_busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd29, 5'd31);
        #1;
        chk("r29_init", rd_data[31:0], 32'h7FFF_EFFC);
        chk("r31_init", rd_data[63:32], 32'h0040_0000);
        check_model("init");
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        #1;
        chk("r5_init", rd_data[31:0], 32'h0);
        chk("init_busy_vec", busy_vec, 32'h0);
        tick();

        // single write, read back on both ports
        drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        #1;
        chk("r3_p0", rd_data[31:0], 32'hDEAD_BEEF);
        chk("r3_p1", rd_data[63:32], 32'hDEAD_BEEF);
        tick();
        // r0 ignores writes and never forwards
        drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        chk("r0_bypass", rd_data[31:0], 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd3);
        #1;
        chk("r0_read", rd_data[31:0], 32'h0);
        chk("r0_busy", busy_vec, 32'h0);
        tick();

        // dual write collision: port1 wins for bypass and storage
        drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
        #1;
        chk("r7_bypass", rd_data[31:0], 32'h22);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        #1;
        chk("r7_stored", rd_data[31:0], 32'h22);
        tick();

        // issue then writeback with forwarding
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
        chk("r9_rd_busy", {31'h0, rd_busy[0]}, 32'h1);
        chk("r9_busy_vec", {31'h0, busy_vec[9]}, 32'h1);
        tick();
        drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
        chk("r9_wb_data", rd_data[31:0], 32'h55);
        chk("r9_wb_rd_busy", {31'h0, rd_busy[0]}, 32'h0);
        chk("r9_wb_busy_vec", {31'h0, busy_vec[9]}, 32'h1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        #1;
        chk("r9_cleared", {31'h0, busy_vec[9]}, 32'h0);
        tick();

        // issue and write in the same cycle: issue wins
        drive(1'b1, 5'd4, 32'hAA, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
        #1;
        chk("r4_data", rd_data[31:0], 32'hAA);
        chk("r4_busy_vec", {31'h0, busy_vec[4]}, 32'h1);
        tick();
        // re-issue of a busy register, then one write clears it
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hBB, 1'b0, 5'd0, 5'd4, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
        #1;
        chk("r4_reissue_clear", {31'h0, busy_vec[4]}, 32'h0);
        chk("r4_reissue_data", rd_data[31:0], 32'hBB);
        tick();

        // reset pulse between edges clears the scoreboard at once
        drive(1'b1, 5'd12, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0);
        #1;
        chk("r12_busy_pre", {31'h0, busy_vec[12]}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy_vec", busy_vec, 32'h0);
        chk("midrst_rd_busy", {30'h0, rd_busy}, 32'h0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("r12_after_rst", rd_data[31:0], 32'h0);
        check_model("post_rst");
        tick();

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), rnum(), $urandom,
                  1'($urandom_range(0, 1)), rnum(), $urandom,
                  1'($urandom_range(0, 2) == 0), rnum(), rnum(), rnum());
            #1;
            check_model($sformatf("rnd%0d", k));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
